// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program-memory fetch stage with flush, timeout and optional prefetch
// Optional one-word sequential prefetch buffer is enabled by defining FETCH_PREFETCH_EN.
module instruction_fetch #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_fetch,
    input  logic [8:0]  in_pc,
    input  logic        in_flush,
    output logic        out_mem_req,
    output logic [8:0]  out_mem_addr,
    input  logic        in_mem_ack,
    input  logic [15:0] in_mem_rdata,
    output logic [15:0] out_ir,
    output logic        out_ir_valid,
    output logic        out_busy,
    output logic        out_fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  wait_inc;
    logic        timeout;

`ifdef FETCH_PREFETCH_EN
    logic [8:0]  mem_addr_q, mem_addr_d;
    logic        pf_valid_q, pf_valid_d;
    logic [8:0]  pf_tag_q, pf_tag_d;
    logic [15:0] pf_data_q, pf_data_d;
    logic        pf_pend_q, pf_pend_d;
    // drain_q: the outstanding background word must come back before the demand address goes out
    logic        drain_q, drain_d;
`endif

    assign wait_inc = wait_q + 8'd1;
    assign timeout  = (wait_inc == TIMEOUT);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_req_d  = mem_req_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q;
        wait_d     = wait_q;
`ifdef FETCH_PREFETCH_EN
        mem_addr_d = mem_addr_q;
        pf_valid_d = pf_valid_q;
        pf_tag_d   = pf_tag_q;
        pf_data_d  = pf_data_q;
        pf_pend_d  = pf_pend_q;
        drain_d    = drain_q;
`endif
        if (in_flush) begin
            state_d    = IDLE;
            mem_req_d  = 1'b0;
            ir_valid_d = 1'b0;
            wait_d     = 8'd0;
`ifdef FETCH_PREFETCH_EN
            pf_valid_d = 1'b0;
            pf_pend_d  = 1'b0;
            drain_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (in_fetch) begin
                        addr_d     = in_pc;
                        ir_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
                        if (pf_valid_q && (in_pc == pf_tag_q)) begin
                            ir_d       = pf_data_q;
                            ir_valid_d = 1'b1;
                            state_d    = DONE;
                            pf_valid_d = 1'b0;
                            pf_pend_d  = 1'b1;
                            mem_req_d  = 1'b1;
                            mem_addr_d = in_pc + 9'd1;
                            wait_d     = 8'd0;
                        end else if (pf_pend_q) begin
                            state_d   = REQ;
                            pf_pend_d = 1'b0;
                            if (in_mem_ack) begin
                                mem_addr_d = in_pc;
                                wait_d     = 8'd0;
                            end else if (timeout) begin
                                state_d   = ERR;
                                err_d     = 1'b1;
                                mem_req_d = 1'b0;
                            end else begin
                                drain_d = 1'b1;
                                wait_d  = wait_inc;
                            end
                        end else begin
                            state_d    = REQ;
                            mem_req_d  = 1'b1;
                            mem_addr_d = in_pc;
                            wait_d     = 8'd0;
                        end
`else
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                        wait_d    = 8'd0;
`endif
                    end
`ifdef FETCH_PREFETCH_EN
                    else if (pf_pend_q) begin
                        if (in_mem_ack) begin
                            pf_data_d  = in_mem_rdata;
                            pf_tag_d   = mem_addr_q;
                            pf_valid_d = 1'b1;
                            pf_pend_d  = 1'b0;
                            mem_req_d  = 1'b0;
                        end else if (timeout) begin
                            state_d    = ERR;
                            err_d      = 1'b1;
                            mem_req_d  = 1'b0;
                            ir_valid_d = 1'b0;
                            pf_pend_d  = 1'b0;
                        end else begin
                            wait_d = wait_inc;
                        end
                    end
`endif
                end
                REQ: begin
                    if (in_mem_ack) begin
`ifdef FETCH_PREFETCH_EN
                        if (drain_q) begin
                            drain_d    = 1'b0;
                            mem_addr_d = addr_q;
                            wait_d     = 8'd0;
                        end else begin
                            ir_d       = in_mem_rdata;
                            ir_valid_d = 1'b1;
                            state_d    = DONE;
                            mem_addr_d = addr_q + 9'd1;
                            pf_pend_d  = 1'b1;
                            pf_valid_d = 1'b0;
                            wait_d     = 8'd0;
                        end
`else
                        ir_d       = in_mem_rdata;
                        ir_valid_d = 1'b1;
                        state_d    = DONE;
                        mem_req_d  = 1'b0;
`endif
                    end else if (timeout) begin
                        state_d   = ERR;
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
                        drain_d   = 1'b0;
`endif
                    end else begin
                        wait_d = wait_inc;
                    end
                end
                default: begin
                    ir_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 9'd0;
            mem_req_q  <= 1'b0;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= 8'd0;
`ifdef FETCH_PREFETCH_EN
            mem_addr_q <= 9'd0;
            pf_valid_q <= 1'b0;
            pf_tag_q   <= 9'd0;
            pf_data_q  <= 16'h0000;
            pf_pend_q  <= 1'b0;
            drain_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_req_q  <= mem_req_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
`ifdef FETCH_PREFETCH_EN
            mem_addr_q <= mem_addr_d;
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            pf_data_q  <= pf_data_d;
            pf_pend_q  <= pf_pend_d;
            drain_q    <= drain_d;
`endif
        end
    end

`ifdef FETCH_PREFETCH_EN
    assign out_mem_addr = mem_addr_q;
`else
    assign out_mem_addr = addr_q;
`endif
    assign out_mem_req   = mem_req_q;
    assign out_ir        = ir_q;
    assign out_ir_valid  = ir_valid_q;
    assign out_busy      = (state_q == REQ);
    assign out_fetch_err = err_q;
endmodule
